rglib_rotate_arb: RTL and testbench

// Shares one rglib_rotate datapath between N_REQ requesters. Round-robin arbitration issues one

---
 rtl/rglib_rotate_arb.sv | 107 ++++++++++
 tb/tb_rglib_rotate_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rglib_rotate_arb.sv
// rglib_rotate_arb: round-robin sharing of one rotator between N_REQ requesters.
// A tag FIFO steers each result back to the requester that issued it.
module rglib_rotate_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int SHIFT_W   = 5,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [N_REQ*DATA_W-1:0]    i_req_data,
    input  logic [N_REQ*SHIFT_W-1:0]   i_req_shift,
    input  logic [N_REQ-1:0]           i_req_dir,
    output logic                       o_in_valid,
    output logic [DATA_W-1:0]          o_in_data,
    output logic [SHIFT_W-1:0]         o_in_shift,
    output logic                       o_in_dir,
    input  logic                       i_out_valid,
    input  logic [DATA_W-1:0]          i_out_data,
    output logic [N_REQ-1:0]           o_rsp_valid,
    output logic [DATA_W-1:0]          o_rsp_data,
    input  logic                       i_flush_req,
    output logic                       o_flush_done,
    output logic                       o_err_orphan
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam logic [CW-1:0]    FULL    = CW'(TAG_DEPTH);
    localparam logic [AW-1:0]    LAST    = AW'(TAG_DEPTH - 1);
    localparam logic [PW-1:0]    PTR_RST = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_ptr, w_win, w_idx;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_wp, r_rp;
    logic [PW-1:0]   r_tag [TAG_DEPTH];
    logic            w_found, w_en, w_accept, w_pop;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Full check uses the pre-update count, so a same-cycle pop never frees a slot early.
    assign w_en         = reset && r_state == RUN && !i_flush_req && r_cnt < FULL;
    assign w_accept     = w_en && w_found;
    assign w_pop        = i_out_valid && r_cnt != '0;
    assign o_req_ready  = w_accept ? (ONE << w_win) : '0;
    assign o_flush_done = r_state == HALT;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == RUN && i_flush_req)   ? DRAIN :
                 (r_state == DRAIN && r_cnt == '0) ? HALT  :
                 (r_state == HALT && !i_flush_req) ? RUN   : r_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= RUN;
            r_ptr        <= PTR_RST;
            r_cnt        <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            o_in_valid   <= 1'b0;
            o_in_data    <= '0;
            o_in_shift   <= '0;
            o_in_dir     <= 1'b0;
            o_rsp_valid  <= '0;
            o_rsp_data   <= '0;
            o_err_orphan <= 1'b0;
        end else begin
            r_state     <= w_next;
            o_in_valid  <= w_accept;
            o_rsp_valid <= w_pop ? (ONE << r_tag[r_rp]) : '0;
            r_cnt       <= r_cnt + CW'(w_accept) - CW'(w_pop);
            if (w_accept) begin
                o_in_data     <= i_req_data[w_win*DATA_W +: DATA_W];
                o_in_shift    <= i_req_shift[w_win*SHIFT_W +: SHIFT_W];
                o_in_dir      <= i_req_dir[w_win];
                r_ptr         <= w_win;
                r_tag[r_wp]   <= w_win;
                r_wp          <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                o_rsp_data <= i_out_data;
                r_rp       <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
            end
            if (i_out_valid && r_cnt == '0)
                o_err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rglib_rotate_arb.sv
// tb_rglib_rotate_arb: directed vectors for round-robin order, result routing,
// back-pressure, flush handshake, orphan detection and reset with ops in flight.
module tb_rglib_rotate_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid, req_ready, req_dir, rsp_valid;
    logic [127:0] req_data;
    logic [19:0] req_shift;
    logic        in_valid, in_dir, out_valid, flush_req, flush_done, err_orphan;
    logic [31:0] in_data, out_data, rsp_data;
    logic [4:0]  in_shift;

    always #5 clk = ~clk;

    rglib_rotate_arb dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_data(req_data),
        .i_req_shift(req_shift), .i_req_dir(req_dir),
        .o_in_valid(in_valid), .o_in_data(in_data), .o_in_shift(in_shift), .o_in_dir(in_dir),
        .i_out_valid(out_valid), .i_out_data(out_data),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .i_flush_req(flush_req), .o_flush_done(flush_done), .o_err_orphan(err_orphan)
    );

    typedef struct { logic [3:0] req; logic [3:0] rdy; } vec_t;
    vec_t        tbl [12];
    logic [31:0] dat [4];
    logic [4:0]  sh  [4];
    logic        dr  [4];
    int          errs = 0, checks = 0;
    logic        auto_rot = 1'b0, pv = 1'b0;
    logic [31:0] pd = '0;

    function automatic logic [31:0] rot(input logic [31:0] d, input logic [4:0] s, input logic r);
        logic [63:0] t;
        t = r ? ({d, d} >> s) : ({d, d} << s);
        return r ? t[31:0] : t[63:32];
    endfunction

    function automatic int idx_of(input logic [3:0] oh);
        for (int j = 0; j < 4; j++) if (oh[j]) return j;
        return 0;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Optional latency-1 rotator stand-in fed from the DUT's in_* port.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_rot) begin
            out_valid = pv;
            out_data  = pd;
        end
        pv = in_valid;
        pd = rot(in_data, in_shift, in_dir);
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; flush_req = 1'b0; out_valid = 1'b0; pv = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    initial begin
        dat = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0001, 32'h0F0F_00FF};
        sh  = '{5'd3, 5'd17, 5'd1, 5'd31};
        dr  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 4; j++) begin
            req_data[j*32 +: 32] = dat[j];
            req_shift[j*5 +: 5]  = sh[j];
            req_dir[j]           = dr[j];
        end
        tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
                '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b1010, 4'b0010},
                '{4'b1010, 4'b1000}, '{4'b0100, 4'b0100}, '{4'b0000, 4'b0000},
                '{4'b0011, 4'b0001}, '{4'b0001, 4'b0001}, '{4'b1001, 4'b1000}};
        req_valid = '0; flush_req = 1'b0; out_valid = 1'b0; out_data = '0;

        // Reset state, sampled while reset is still asserted
        step(); step();
        chk("rst_in_valid", in_valid, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_err", err_orphan, 0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b1;

        // Round-robin table with a latency-1 rotator looped back
        auto_rot = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].req;
            #1;
            chk("rr_ready", req_ready, tbl[i].rdy);
            if (i >= 1) begin
                chk("rr_in_valid", in_valid, tbl[i-1].rdy != 0);
                if (tbl[i-1].rdy != 0)
                    chk("rr_in_data", in_data, dat[idx_of(tbl[i-1].rdy)]);
            end
            if (i >= 3) begin
                chk("rr_rsp_valid", rsp_valid, tbl[i-3].rdy);
                if (tbl[i-3].rdy != 0)
                    chk("rr_rsp_data", rsp_data,
                        rot(dat[idx_of(tbl[i-3].rdy)], sh[idx_of(tbl[i-3].rdy)], dr[idx_of(tbl[i-3].rdy)]));
            end
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
        auto_rot = 1'b0;
        out_valid = 1'b0;

        // Requester 2 single operation, manual rotator
        do_reset();
        req_valid = 4'b0100;
        #1;
        chk("r2_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("r2_in_valid", in_valid, 1);
        chk("r2_in_data", in_data, 32'h8000_0001);
        chk("r2_in_shift", in_shift, 1);
        chk("r2_in_dir", in_dir, 0);
        out_valid = 1'b1; out_data = 32'h0000_0003;
        step();
        out_valid = 1'b0;
        chk("r2_rsp_valid", rsp_valid, 4'b0100);
        chk("r2_rsp_data", rsp_data, 32'h0000_0003);
        chk("r2_in_idle", in_valid, 0);
        chk("r2_in_hold", in_data, 32'h8000_0001);
        step();
        chk("r2_rsp_clear", rsp_valid, 0);

        // Stalled rotator: four grants fill the tag FIFO
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_grant", req_ready, 4'b0001 << k);
            step();
        end
        #1;
        chk("stall_full", req_ready, 0);
        step();
        out_valid = 1'b1; out_data = 32'h55;
        #1;
        chk("stall_pop_no_grant", req_ready, 0);
        step();
        out_valid = 1'b0;
        #1;
        chk("stall_regrant", req_ready, 4'b0001);
        chk("stall_rsp_valid", rsp_valid, 4'b0001);
        chk("stall_rsp_data", rsp_data, 32'h55);
        step();
        #1;
        chk("stall_refull", req_ready, 0);

        // Flush with three ops in flight
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fl_grant", req_ready, 4'b0001 << k);
            step();
        end
        flush_req = 1'b1;
        #1;
        chk("fl_same_cycle", req_ready, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            out_valid = 1'b1; out_data = 32'h100 + k;
            #1;
            chk("fl_drain_ready", req_ready, 0);
            chk("fl_drain_done", flush_done, 0);
            if (k >= 1) chk("fl_rsp_valid", rsp_valid, 4'b0001 << (k - 1));
            step();
        end
        out_valid = 1'b0;
        chk("fl_rsp_last", rsp_valid, 4'b0100);
        chk("fl_rsp_last_data", rsp_data, 32'h102);
        chk("fl_not_yet_done", flush_done, 0);
        step();
        chk("fl_done", flush_done, 1);
        chk("fl_halt_ready", req_ready, 0);
        flush_req = 1'b0;
        #1;
        chk("fl_halt_hold", req_ready, 0);
        step();
        #1;
        chk("fl_resume_done", flush_done, 0);
        chk("fl_resume_ready", req_ready, 4'b1000);

        // Orphan return is sticky until reset
        do_reset();
        out_valid = 1'b1; out_data = 32'hBAD;
        step();
        out_valid = 1'b0;
        chk("orph_err", err_orphan, 1);
        chk("orph_rsp", rsp_valid, 0);
        step(); step(); step();
        chk("orph_sticky", err_orphan, 1);

        // Reset with two ops in flight
        do_reset();
        chk("rr_err_cleared", err_orphan, 0);
        req_valid = 4'b0011;
        step(); step();
        req_valid = '0;
        reset = 1'b0;
        out_valid = 1'b1;
        step();
        chk("mid_in_valid", in_valid, 0);
        chk("mid_in_data", in_data, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_err", err_orphan, 0);
        chk("mid_ready", req_ready, 0);
        out_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_err_after_release", err_orphan, 0);
        out_valid = 1'b1;
        step();
        out_valid = 1'b0;
        chk("mid_stray_err", err_orphan, 1);
        chk("mid_stray_rsp", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
